// File: rtl/teclado_pkg.sv
// Shared constants for the push-button front-end and the keyboard input register.
package teclado_pkg;

  localparam int unsigned N_BTN = 7;

  localparam int unsigned BTN_AUMENTA   = 0;
  localparam int unsigned BTN_DISMINUYE = 1;
  localparam int unsigned BTN_SIGUIENTE = 2;
  localparam int unsigned BTN_ANTERIOR  = 3;
  localparam int unsigned BTN_FORMATO   = 4;
  localparam int unsigned BTN_CAMBIA    = 5;
  localparam int unsigned BTN_QUITA     = 6;

  localparam logic [7:0] PORT_AUMENTA   = 8'h03;
  localparam logic [7:0] PORT_DISMINUYE = 8'h04;
  localparam logic [7:0] PORT_SIGUIENTE = 8'h05;
  localparam logic [7:0] PORT_ANTERIOR  = 8'h06;
  localparam logic [7:0] PORT_FORMATO   = 8'h07;
  localparam logic [7:0] PORT_CAMBIA    = 8'h08;
  localparam logic [7:0] PORT_QUITA     = 8'h09;

  // Read port that clears the pending flag of button idx.
  function automatic logic [7:0] btn_port(input int unsigned idx);
    case (idx)
      BTN_AUMENTA:   btn_port = PORT_AUMENTA;
      BTN_DISMINUYE: btn_port = PORT_DISMINUYE;
      BTN_SIGUIENTE: btn_port = PORT_SIGUIENTE;
      BTN_ANTERIOR:  btn_port = PORT_ANTERIOR;
      BTN_FORMATO:   btn_port = PORT_FORMATO;
      BTN_CAMBIA:    btn_port = PORT_CAMBIA;
      BTN_QUITA:     btn_port = PORT_QUITA;
      default:       btn_port = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/antirrebote.sv
// One button: 2-flop synchroniser, stability counter and debounced level with press pulse.
module antirrebote #(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned CNT_W      = $clog2(DEB_CYCLES)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (s2_q != stable_q) begin
      if (cnt_q == CntMax) begin
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= btn_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  // Asserted in the cycle whose edge takes stable 0->1, so the flag sets on that same edge.
  assign press_o  = stable_d & ~stable_q;

endmodule

// File: rtl/captura_teclado.sv
// Seven debounced buttons turned into sticky pending flags cleared by port reads, plus IRQ.
module captura_teclado
  import teclado_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned CNT_W      = $clog2(DEB_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [7:0]       port_id,
  input  logic             read_strobe,
  input  logic             interrupt_ack,
  output logic             aumenta,
  output logic             disminuye,
  output logic             siguiente,
  output logic             anterior,
  output logic             formato,
  output logic             cambia,
  output logic             quita,
  output logic             interrupcion
);

  logic [N_BTN-1:0] stable, press, clr;
  logic [N_BTN-1:0] flag_q, flag_d;
  logic             new_q, new_d;
  logic             intr_q, intr_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_deb
    antirrebote #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_deb (
      .clk_i   (clk),
      .rst_ni  (reset),
      .btn_i   (btn_raw[i]),
      .stable_o(stable[i]),
      .press_o (press[i])
    );

    press_follows_stable: assert property (@(posedge clk) disable iff (!reset)
      press[i] |=> stable[i]);
  end

  always_comb begin
    for (int unsigned i = 0; i < N_BTN; i++) begin
      clr[i] = read_strobe && (port_id == btn_port(i));
    end
    // Press has priority over a simultaneous read so no press is lost.
    flag_d = press | (flag_q & ~clr);
    new_d  = |(press & ~flag_q);
    intr_d = new_q | (intr_q & ~interrupt_ack);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q <= '0;
      new_q  <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
      new_q  <= new_d;
      intr_q <= intr_d;
    end
  end

  assign aumenta      = flag_q[BTN_AUMENTA];
  assign disminuye    = flag_q[BTN_DISMINUYE];
  assign siguiente    = flag_q[BTN_SIGUIENTE];
  assign anterior     = flag_q[BTN_ANTERIOR];
  assign formato      = flag_q[BTN_FORMATO];
  assign cambia       = flag_q[BTN_CAMBIA];
  assign quita        = flag_q[BTN_QUITA];
  assign interrupcion = intr_q;

endmodule

// File: tb/tb_captura_teclado.sv
// Directed bench for captura_teclado with DEB_CYCLES=4.
module tb_captura_teclado;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] btn_raw = '0;
  logic [7:0] port_id = '0;
  logic       read_strobe = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic       aumenta, disminuye, siguiente, anterior, formato, cambia, quita, interrupcion;

  int checks = 0;
  int failures = 0;
  int dis_ev = 0;
  int ev0;
  logic dis_prev = 1'b0;

  captura_teclado #(
    .DEB_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_raw      (btn_raw),
    .port_id      (port_id),
    .read_strobe  (read_strobe),
    .interrupt_ack(interrupt_ack),
    .aumenta      (aumenta),
    .disminuye    (disminuye),
    .siguiente    (siguiente),
    .anterior     (anterior),
    .formato      (formato),
    .cambia       (cambia),
    .quita        (quita),
    .interrupcion (interrupcion)
  );

  always #5 clk = ~clk;

  // Counts rising edges of the disminuye flag.
  always @(negedge clk) begin
    if (disminuye && !dis_prev) dis_ev <= dis_ev + 1;
    dis_prev <= disminuye;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_port(input logic [7:0] p);
    port_id     = p;
    read_strobe = 1'b1;
    step(1);
    read_strobe = 1'b0;
    port_id     = 8'h00;
  endtask

  task automatic ack_irq();
    interrupt_ack = 1'b1;
    step(1);
    interrupt_ack = 1'b0;
  endtask

  function automatic logic [7:0] all_outs();
    return {interrupcion, quita, cambia, formato, anterior, siguiente, disminuye, aumenta};
  endfunction

  initial begin
    // 1: reset behaviour and press latency
    step(3);
    check_eq("reset_outs", 32'(all_outs()), 32'h0);
    reset = 1'b1;
    btn_raw[0] = 1'b1;
    step(8);
    check_eq("aum_pre_set", 32'(aumenta), 32'h1);
    check_eq("irq_pre_set", 32'(interrupcion), 32'h1);
    step(1);
    #3 reset = 1'b0;
    #1 check_eq("async_reset_outs", 32'(all_outs()), 32'h0);
    @(negedge clk) reset = 1'b1;
    step(5);
    check_eq("aum_lat5", 32'(aumenta), 32'h0);
    step(1);
    check_eq("aum_lat6", 32'(aumenta), 32'h1);
    check_eq("irq_lat6", 32'(interrupcion), 32'h0);
    step(1);
    check_eq("irq_lat7", 32'(interrupcion), 32'h1);
    ack_irq();
    check_eq("irq_acked", 32'(interrupcion), 32'h0);
    check_eq("aum_after_ack", 32'(aumenta), 32'h1);
    read_port(8'h03);
    check_eq("aum_read", 32'(aumenta), 32'h0);
    check_eq("irq_after_read", 32'(interrupcion), 32'h0);
    btn_raw[0] = 1'b0;
    step(10);

    // 2: short glitch ignored, long press accepted
    btn_raw[5] = 1'b1;
    step(3);
    btn_raw[5] = 1'b0;
    step(10);
    check_eq("cambia_glitch", 32'(cambia), 32'h0);
    check_eq("irq_glitch", 32'(interrupcion), 32'h0);
    btn_raw[5] = 1'b1;
    step(10);
    check_eq("cambia_long", 32'(cambia), 32'h1);
    ack_irq();
    read_port(8'h08);
    check_eq("cambia_read", 32'(cambia), 32'h0);
    btn_raw[5] = 1'b0;
    step(10);

    // 3: port decode for quita
    btn_raw[6] = 1'b1;
    step(8);
    check_eq("quita_set", 32'(quita), 32'h1);
    ack_irq();
    read_port(8'h08);
    check_eq("quita_wrong_port", 32'(quita), 32'h1);
    port_id = 8'h09;
    step(1);
    port_id = 8'h00;
    check_eq("quita_no_strobe", 32'(quita), 32'h1);
    read_port(8'h09);
    check_eq("quita_read", 32'(quita), 32'h0);
    btn_raw[6] = 1'b0;
    step(10);
    check_eq("quita_release", 32'(quita), 32'h0);
    check_eq("irq_after_quita", 32'(interrupcion), 32'h0);

    // 4: press and read of formato on the same edge
    btn_raw[4] = 1'b1;
    step(5);
    check_eq("formato_pre", 32'(formato), 32'h0);
    port_id     = 8'h07;
    read_strobe = 1'b1;
    step(1);
    read_strobe = 1'b0;
    port_id     = 8'h00;
    check_eq("formato_set_wins", 32'(formato), 32'h1);
    step(1);
    check_eq("irq_formato", 32'(interrupcion), 32'h1);
    ack_irq();
    read_port(8'h07);
    check_eq("formato_read", 32'(formato), 32'h0);
    btn_raw[4] = 1'b0;
    step(10);

    // 5: ack coincident with interrupt set
    btn_raw[2] = 1'b1;
    step(5);
    check_eq("sig_pre", 32'(siguiente), 32'h0);
    step(1);
    check_eq("sig_set", 32'(siguiente), 32'h1);
    check_eq("irq_before_set", 32'(interrupcion), 32'h0);
    ack_irq();
    check_eq("irq_set_wins", 32'(interrupcion), 32'h1);
    step(2);
    ack_irq();
    check_eq("irq_ack_alone", 32'(interrupcion), 32'h0);
    check_eq("sig_kept", 32'(siguiente), 32'h1);
    read_port(8'h05);
    btn_raw[2] = 1'b0;
    step(10);

    // 6: bouncy press on disminuye, then a release/press cycle
    ev0 = dis_ev;
    for (int k = 0; k < 3; k++) begin
      btn_raw[1] = 1'b1;
      step(2);
      btn_raw[1] = 1'b0;
      step(2);
    end
    check_eq("dis_bounce", 32'(disminuye), 32'h0);
    btn_raw[1] = 1'b1;
    step(10);
    check_eq("dis_steady", 32'(disminuye), 32'h1);
    read_port(8'h04);
    check_eq("dis_read", 32'(disminuye), 32'h0);
    btn_raw[1] = 1'b0;
    step(10);
    check_eq("dis_release", 32'(disminuye), 32'h0);
    btn_raw[1] = 1'b1;
    step(10);
    check_eq("dis_repress", 32'(disminuye), 32'h1);
    step(1);
    check_eq("dis_events", 32'(dis_ev - ev0), 32'd2);
    check_eq("others_idle", 32'({anterior, quita, cambia, formato, siguiente, aumenta}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
